// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: valid/ready byte stream to asynchronous serial frames on tx.
// Frame is start, DATA_BITS data (LSB first), optional parity, STOP_BITS stop bits.
module uart_tx_serializer #(
   parameter int DATA_BITS  = 8,
   parameter int DIVISOR    = 868,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic                 s_clk,
   input  logic                 s_rst_n,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [DATA_BITS-1:0] s_data,
   output logic                 tx,
   output logic                 busy,
   output logic                 tx_done
);
   localparam int DW = $clog2(DIVISOR);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state_q, state_d;
   logic [DW-1:0]        div_q, div_d;
   logic [2:0]           bit_q, bit_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_q, par_d;
   logic                 tx_q, tx_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 bit_end;

   assign bit_end = div_q == DW'(DIVISOR - 1);
   assign s_ready = (state_q == IDLE) & s_rst_n;
   assign tx      = tx_q;
   assign busy    = busy_q;
   assign tx_done = done_q;

   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      par_d   = par_q;
      done_d  = 1'b0;
      if (state_q != IDLE) div_d = bit_end ? '0 : div_q + DW'(1);
      case (state_q)
         IDLE: if (s_valid & s_ready) begin
            shift_d = s_data;
            par_d   = ^s_data ^ (PARITY_ODD != 0);
            div_d   = '0;
            bit_d   = '0;
            state_d = START;
         end
         START: if (bit_end) state_d = DATA;
         DATA: if (bit_end) begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'(DATA_BITS - 1)) begin
               bit_d   = '0;
               state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
         end
         PARITY: if (bit_end) state_d = STOP;
         STOP: if (bit_end) begin
            bit_d = bit_q + 3'd1;
            if (bit_q == 3'(STOP_BITS - 1)) begin
               bit_d   = '0;
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      busy_d = state_d != IDLE;
      // tx follows the current state, so the line lags the state register by one cycle
      tx_d = (state_q == START)  ? 1'b0 :
             (state_q == DATA)   ? shift_q[0] :
             (state_q == PARITY) ? par_q : 1'b1;
   end

   always_ff @(posedge s_clk) begin
      if (!s_rst_n) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end
endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: directed bench over 8N1, 8E1, 8O1 and 8N2 instances at DIVISOR=4.
// A per-channel serial sampling monitor checks received frames against a scoreboard queue.
module tb_uart_tx_serializer;
   localparam int PE[4] = '{0, 1, 1, 0};
   localparam int PO[4] = '{0, 0, 1, 0};
   localparam int NS[4] = '{1, 1, 1, 2};

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] valid, ready, tx, busy, done;
   logic [7:0] data[4];
   logic [8:0] exp_q[4][$];
   int         total = 0, bad = 0;
   time        hs_t, t1, t2;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      uart_tx_serializer #(
         .DATA_BITS(8), .DIVISOR(4), .PARITY_EN(PE[g]), .PARITY_ODD(PO[g]), .STOP_BITS(NS[g])
      ) u_dut (
         .s_clk(clk), .s_rst_n(rst_n), .s_valid(valid[g]), .s_ready(ready[g]),
         .s_data(data[g]), .tx(tx[g]), .busy(busy[g]), .tx_done(done[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [11:0] frame_bits(input int ch, input logic [7:0] d);
      logic [11:0] f;
      f = '1;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) f[1+i] = d[i];
      if (PE[ch] != 0) f[9] = ^d ^ (PO[ch] != 0);
      return f;
   endfunction

   task automatic monitor(input int ch);
      logic [11:0] got;
      logic [8:0]  e;
      int          nb;
      bit          ab;
      nb = 9 + PE[ch] + NS[ch];
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && tx[ch] === 1'b0) begin
            got = '1;
            ab  = 0;
            for (int c = 1; c <= 4 * (nb - 1) + 2 && !ab; c++) begin
               @(negedge clk);
               if (rst_n !== 1'b1) ab = 1;
               else if (c % 4 == 2) got[c/4] = tx[ch];
            end
            if (!ab) begin
               if (exp_q[ch].size() == 0) chk($sformatf("mon%0d_extra", ch), 1, 0);
               else begin
                  e = exp_q[ch].pop_front();
                  chk($sformatf("mon%0d_start", ch), 32'(got[0]), 0);
                  chk($sformatf("mon%0d_data", ch), 32'(got[8:1]), 32'(e[7:0]));
                  if (PE[ch] != 0) chk($sformatf("mon%0d_par", ch), 32'(got[9]), 32'(e[8]));
                  for (int s = 0; s < NS[ch]; s++)
                     chk($sformatf("mon%0d_stop%0d", ch, s), 32'(got[9+PE[ch]+s]), 1);
               end
            end
         end
      end
   endtask

   task automatic send_check(input int ch, input logic [7:0] d, input bit hold);
      logic [11:0] f;
      int          nb, w;
      f  = frame_bits(ch, d);
      nb = 9 + PE[ch] + NS[ch];
      exp_q[ch].push_back({(PE[ch] != 0) ? f[9] : 1'b0, d});
      valid[ch] = 1'b1;
      data[ch]  = d;
      w = 0;
      while (!ready[ch] && w < 200) begin
         @(negedge clk);
         w++;
      end
      if (!ready[ch]) begin
         chk($sformatf("ch%0d_hs_timeout", ch), 0, 1);
         valid[ch] = 1'b0;
         return;
      end
      @(posedge clk);
      hs_t = $time;
      for (int k = 0; k <= nb * 4; k++) begin
         @(negedge clk);
         if (k == 0 && !hold) valid[ch] = 1'b0;
         chk($sformatf("ch%0d_%0h_tx_k%0d", ch, d, k), 32'(tx[ch]), (k == 0) ? 1 : 32'(f[(k-1)/4]));
         chk($sformatf("ch%0d_%0h_done_k%0d", ch, d, k), 32'(done[ch]), 32'(k == nb * 4));
         chk($sformatf("ch%0d_%0h_busy_k%0d", ch, d, k), 32'(busy[ch]), 32'(k != nb * 4));
      end
      chk($sformatf("ch%0d_%0h_ready_end", ch, d), 32'(ready[ch]), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      valid = '0;
      for (int i = 0; i < 4; i++) data[i] = '0;
      fork
         monitor(0); monitor(1); monitor(2); monitor(3);
      join_none
      repeat (3) begin
         @(negedge clk);
         chk("rst_tx", 32'(tx), 32'hf);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_done", 32'(done), 0);
         chk("rst_ready", 32'(ready), 0);
      end
      rst_n = 1'b1;
      #1 chk("rel_ready_now", 32'(ready), 32'hf);
      @(negedge clk);
      chk("rel_ready", 32'(ready), 32'hf);
      chk("rel_tx", 32'(tx), 32'hf);
      send_check(0, 8'h55, 0);
      @(negedge clk);
      send_check(1, 8'h07, 0);
      chk("even_par_bit", 32'(frame_bits(1, 8'h07) >> 9) & 1, 1);
      @(negedge clk);
      send_check(2, 8'h07, 0);
      chk("odd_par_bit", 32'(frame_bits(2, 8'h07) >> 9) & 1, 0);
      @(negedge clk);
      send_check(3, 8'hA3, 1);
      t1 = hs_t;
      send_check(3, 8'h3C, 0);
      t2 = hs_t;
      chk("n2_hs_spacing", 32'((t2 - t1) / 10), 45);
      // truncated frame: nothing is pushed, the monitor aborts on reset
      @(negedge clk);
      valid[0] = 1'b1;
      data[0]  = 8'hF0;
      @(posedge clk);
      for (int k = 0; k <= 18; k++) begin
         @(negedge clk);
         if (k == 0) valid[0] = 1'b0;
         else chk($sformatf("f0_tx_k%0d", k), 32'(tx[0]), 32'(frame_bits(0, 8'hF0) >> ((k - 1) / 4)) & 1);
      end
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid_rst_tx", 32'(tx[0]), 1);
      chk("mid_rst_busy", 32'(busy[0]), 0);
      chk("mid_rst_done", 32'(done[0]), 0);
      chk("mid_rst_ready", 32'(ready[0]), 0);
      @(negedge clk);
      chk("mid_rst_done2", 32'(done[0]), 0);
      rst_n = 1'b1;
      #1 chk("mid_rel_ready", 32'(ready[0]), 1);
      @(negedge clk);
      chk("mid_rel_tx", 32'(tx[0]), 1);
      chk("mid_rel_done", 32'(done[0]), 0);
      send_check(0, 8'h81, 0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         chk($sformatf("bp_tx_%0d", i), 32'(tx[0]), 1);
         chk($sformatf("bp_ready_%0d", i), 32'(ready[0]), 1);
      end
      send_check(0, 8'h00, 0);
      repeat (8) @(negedge clk);
      for (int i = 0; i < 4; i++) chk($sformatf("q%0d_empty", i), 32'(exp_q[i].size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
